abacus_instruction_classifier: RTL and testbench



---
 rtl/abacus_pkg.sv | 59 +++++
 rtl/abacus_rv32_class_decode.sv | 53 +++++
 rtl/abacus_instruction_classifier.sv | 80 ++++++++
 tb/tb_abacus_instruction_classifier.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/abacus_pkg.sv
// Shared definitions for the ABACUS instruction-mix profiler.
// Opcodes, class ordering and small helpers used by decode and counters.
package abacus_pkg;

    localparam int NUM_CLASSES = 10;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Bit position in class_onehot; shared with counter bank and regmap.
    typedef enum logic [3:0] {
        CLS_LOAD     = 4'd0,
        CLS_STORE    = 4'd1,
        CLS_ADD      = 4'd2,
        CLS_BITWISE  = 4'd3,
        CLS_SHIFT    = 4'd4,
        CLS_COMPARE  = 4'd5,
        CLS_BRANCH   = 4'd6,
        CLS_CTRL     = 4'd7,
        CLS_SYSTEM   = 4'd8,
        CLS_ATOMIC   = 4'd9
    } instr_class_e;

    // funct3 map shared by OP-IMM and base-ISA OP.
    function automatic instr_class_e alu_class(input logic [2:0] funct3);
        instr_class_e c;
        case (funct3)
            3'b000:                 c = CLS_ADD;
            3'b001, 3'b101:         c = CLS_SHIFT;
            3'b010, 3'b011:         c = CLS_COMPARE;
            default:                c = CLS_BITWISE;
        endcase
        return c;
    endfunction

    function automatic logic [NUM_CLASSES-1:0] class_to_onehot(
        input instr_class_e c
    );
        return NUM_CLASSES'(1) << c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/abacus_rv32_class_decode.sv
// Combinational RV32 instruction classifier.
// Maps one instruction word to a one-hot profiling class or unclassified.
module abacus_rv32_class_decode
    import abacus_pkg::*;
(
    input  logic [31:0]            instr_i,
    output logic [NUM_CLASSES-1:0] onehot_o,
    output logic                   unclassified_o
);

    logic [6:0]   opcode;
    logic [6:0]   funct7;
    logic [2:0]   funct3;
    logic         hit;
    instr_class_e cls;
    logic         unused_bits;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign funct7      = instr_i[31:25];
    assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

    // Opcode decode; non-32-bit encodings never hit.
    always_comb begin
        cls = CLS_LOAD;
        hit = 1'b0;
        if (instr_i[1:0] == 2'b11) begin
            hit = 1'b1;
            case (opcode)
                OPC_LOAD:              cls = CLS_LOAD;
                OPC_STORE:             cls = CLS_STORE;
                OPC_LUI, OPC_AUIPC:    cls = CLS_ADD;
                OPC_OP_IMM:            cls = alu_class(funct3);
                OPC_OP: begin
                    if (funct7 == F7_BASE || funct7 == F7_ALT)
                        cls = alu_class(funct3);
                    else
                        hit = 1'b0;
                end
                OPC_BRANCH:            cls = CLS_BRANCH;
                OPC_JAL, OPC_JALR:     cls = CLS_CTRL;
                OPC_SYSTEM,
                OPC_MISC_MEM:          cls = CLS_SYSTEM;
                OPC_AMO:               cls = CLS_ATOMIC;
                default:               hit = 1'b0;
            endcase
        end
    end

    assign onehot_o       = hit ? class_to_onehot(cls) : '0;
    assign unclassified_o = ~hit;

endmodule

// File: rtl/abacus_instruction_classifier.sv
// Two-stage instruction-mix classifier with saturating totals.
// Stage 0 captures issued words; stage 1 emits the class event.
module abacus_instruction_classifier
    import abacus_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [31:0]            instruction,
    input  logic                   instruction_issued,
    input  logic                   clear_counts,
    output logic                   class_valid,
    output logic [NUM_CLASSES-1:0] class_onehot,
    output logic [31:0]            issued_count,
    output logic [31:0]            unclassified_count
);

    logic                   s0_valid_q;
    logic [31:0]            s0_instr_q;
    logic                   s1_valid_q, s1_valid_d;
    logic [NUM_CLASSES-1:0] s1_onehot_q, s1_onehot_d;
    logic [31:0]            issued_q, issued_d;
    logic [31:0]            unclass_q, unclass_d;
    logic [NUM_CLASSES-1:0] dec_onehot;
    logic                   dec_unclassified;

    // Stage 0: capture word; enable only gates acceptance here.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_instr_q <= '0;
        end else begin
            s0_valid_q <= instruction_issued & enable;
            s0_instr_q <= instruction;
        end
    end

    abacus_rv32_class_decode u_decode (
        .instr_i        (s0_instr_q),
        .onehot_o       (dec_onehot),
        .unclassified_o (dec_unclassified)
    );

    // Stage-1 event and counter next-state; clear beats increment.
    always_comb begin
        s1_valid_d  = s0_valid_q & ~dec_unclassified;
        s1_onehot_d = s1_valid_d ? dec_onehot : '0;
        issued_d    = issued_q;
        unclass_d   = unclass_q;
        if (clear_counts) begin
            issued_d  = '0;
            unclass_d = '0;
        end else if (s0_valid_q) begin
            issued_d = sat_inc(issued_q);
            if (dec_unclassified)
                unclass_d = sat_inc(unclass_q);
        end
    end

    // Stage 1 and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_onehot_q <= '0;
            issued_q    <= '0;
            unclass_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_onehot_q <= s1_onehot_d;
            issued_q    <= issued_d;
            unclass_q   <= unclass_d;
        end
    end

    assign class_valid        = s1_valid_q;
    assign class_onehot       = s1_onehot_q;
    assign issued_count       = issued_q;
    assign unclassified_count = unclass_q;

endmodule

// File: tb/tb_abacus_instruction_classifier.sv
// Scoreboard bench for abacus_instruction_classifier.
// Directed issue vectors; a monitor pops expected events on class_valid.
module tb_abacus_instruction_classifier;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] instruction;
    logic        instruction_issued;
    logic        clear_counts;
    logic        class_valid;
    logic [9:0]  class_onehot;
    logic [31:0] issued_count;
    logic [31:0] unclassified_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [9:0] exp_q[$];
    int         cyc_q[$];

    abacus_instruction_classifier dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .instruction        (instruction),
        .instruction_issued (instruction_issued),
        .clear_counts       (clear_counts),
        .class_valid        (class_valid),
        .class_onehot       (class_onehot),
        .issued_count       (issued_count),
        .unclassified_count (unclassified_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (class_valid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL event: unexpected onehot=%h at cyc %0d",
                         class_onehot, cyc);
            end else begin
                logic [9:0] e;
                int         c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                if (class_onehot !== e || cyc != c) begin
                    errors = errors + 1;
                    $display("FAIL event: got %h at cyc %0d, want %h at cyc %0d",
                             class_onehot, cyc, e, c);
                end
            end
        end else if (class_onehot !== 10'd0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL idle_onehot: got %h want 000", class_onehot);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one issue at this negedge; push expected event if classified.
    task automatic issue(input logic [31:0] w, input logic [9:0] e);
        instruction        = w;
        instruction_issued = 1'b1;
        if (enable && e != 10'd0) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc + 2);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        instruction_issued = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst                = 1'b1;
        enable             = 1'b0;
        instruction        = '0;
        instruction_issued = 1'b0;
        clear_counts       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, class_valid}, 32'd0);
        chk("rst_onehot", {22'd0, class_onehot}, 32'd0);
        chk("rst_issued", issued_count, 32'd0);
        chk("rst_unclass", unclassified_count, 32'd0);

        // Single ADDI issued in the first cycle after reset.
        rst    = 1'b0;
        enable = 1'b1;
        issue(32'h0050_0093, 10'h004);
        idle(1);
        chk("addi_issued", issued_count, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_valid", {31'd0, class_valid}, 32'd0);
        chk("rst2_issued", issued_count, 32'd0);

        // Back-to-back mix.
        issue(32'h0000_A083, 10'h001);
        issue(32'h0010_A023, 10'h002);
        issue(32'h0000_0063, 10'h040);
        issue(32'h0000_006F, 10'h080);
        issue(32'h0020_A2AF, 10'h200);
        idle(1);
        chk("mix_issued", issued_count, 32'd5);
        chk("mix_unclass", unclassified_count, 32'd0);
        idle(1);

        // Clear, then unclassified words.
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        chk("clr_issued", issued_count, 32'd0);
        issue(32'h0220_8033, 10'h000);
        issue(32'h0000_0001, 10'h000);
        idle(2);
        chk("unc_unclass", unclassified_count, 32'd2);
        chk("unc_issued", issued_count, 32'd2);

        // Enable gating: SLLI counts, XOR after enable drop does not.
        issue(32'h0010_9093, 10'h010);
        enable = 1'b0;
        issue(32'h0020_C0B3, 10'h008);
        idle(3);
        chk("gate_issued", issued_count, 32'd3);
        chk("gate_unclass", unclassified_count, 32'd2);
        enable = 1'b1;

        // Saturation.
        force dut.issued_q = 32'hFFFF_FFFE;
        #1;
        release dut.issued_q;
        @(negedge clk);
        issue(32'h0050_0093, 10'h004);
        issue(32'h0000_A083, 10'h001);
        issue(32'h0000_0063, 10'h040);
        idle(3);
        chk("sat_issued", issued_count, 32'hFFFF_FFFF);
        chk("sat_unclass", unclassified_count, 32'd2);

        // Clear in the same cycle as a stage-1 event.
        issue(32'h0050_0093, 10'h004);
        instruction_issued = 1'b0;
        clear_counts       = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        chk("clr_ev_issued", issued_count, 32'd0);
        chk("clr_ev_unclass", unclassified_count, 32'd0);
        idle(2);
        chk("clr_ev_after", issued_count, 32'd0);

        // Mid-flight reset discards ECALL.
        issue(32'h0000_0073, 10'h000);
        instruction_issued = 1'b0;
        rst                = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mf_valid", {31'd0, class_valid}, 32'd0);
        idle(3);
        chk("mf_issued", issued_count, 32'd0);
        chk("mf_unclass", unclassified_count, 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
